// File: rtl/lane_departure_detect_if.sv
`default_nettype none
// ============================================================================
// Module  : lane_departure_detect_if
// Purpose : Signal bundle between the sensor/driver-input side and the lane
//           departure front end. Master drives the raw inputs, slave returns
//           the registered assist requests.
// Revision: 1.0 - initial release
// ============================================================================
interface lane_departure_detect_if;
  logic              tick;
  logic              offset_valid;
  logic signed [7:0] offset;
  logic              turn_left;
  logic              turn_right;
  logic              disable_btn;
  logic        [7:0] speed;
  logic              assist_right;
  logic              assist_left;
  logic              assist_disable;
  logic              sensor_fault;

  modport master (
    output tick, offset_valid, offset, turn_left, turn_right, disable_btn, speed,
    input  assist_right, assist_left, assist_disable, sensor_fault
  );

  modport slave (
    input  tick, offset_valid, offset, turn_left, turn_right, disable_btn, speed,
    output assist_right, assist_left, assist_disable, sensor_fault
  );
endinterface
`default_nettype wire

// File: rtl/lane_departure_detect.sv
`default_nettype none
// ============================================================================
// Module  : lane_departure_detect
// Purpose : Qualifies lateral-offset samples into left/right departure
//           requests with persistence and hysteresis, suppresses intentional
//           lane changes around turn signals, debounces the disable button
//           into a toggle and flags a stale lateral sensor.
// Revision: 1.0 - initial release
// ============================================================================
module lane_departure_detect #(
  parameter int THRESH    = 20,
  parameter int HYST      = 5,
  parameter int PERSIST   = 4,
  parameter int HOLDOFF   = 50,
  parameter int DEBOUNCE  = 3,
  parameter int TIMEOUT   = 8,
  parameter int MIN_SPEED = 40
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  lane_departure_detect_if.slave lane_if
);

  localparam int c_hold_w  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int c_stale_w = $clog2(TIMEOUT + 1);
  localparam int c_deb_w   = $clog2(DEBOUNCE + 1);
  localparam int c_pers_w  = $clog2(PERSIST + 1);

  localparam logic [c_hold_w-1:0]  c_hold       = c_hold_w'(HOLDOFF);
  localparam logic [c_hold_w-1:0]  c_hold_one   = c_hold_w'(1);
  localparam logic [c_stale_w-1:0] c_timeout    = c_stale_w'(TIMEOUT);
  localparam logic [c_stale_w-1:0] c_stale_one  = c_stale_w'(1);
  localparam logic [c_deb_w-1:0]   c_deb_last   = c_deb_w'(DEBOUNCE - 1);
  localparam logic [c_deb_w-1:0]   c_deb_one    = c_deb_w'(1);
  localparam logic [c_pers_w-1:0]  c_pers_last  = c_pers_w'(PERSIST - 1);
  localparam logic [c_pers_w-1:0]  c_pers_one   = c_pers_w'(1);
  localparam logic [7:0]           c_min_speed  = 8'(MIN_SPEED);

  // Thresholds held in 9 signed bits so -THRESH and the offset compare cleanly.
  localparam logic signed [8:0] c_thr_pos = 9'(THRESH);
  localparam logic signed [8:0] c_thr_neg = 9'(-THRESH);
  localparam logic signed [8:0] c_clr_pos = 9'(THRESH - HYST);
  localparam logic signed [8:0] c_clr_neg = 9'(HYST - THRESH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PEND_R = 3'd1,
    S_PEND_L = 3'd2,
    S_DEP_R  = 3'd3,
    S_DEP_L  = 3'd4
  } state_t;

  state_t                state_q;
  logic [c_pers_w-1:0]   pers_q;
  logic                  assist_r_q, assist_l_q;
  logic [c_hold_w-1:0]   hold_r_q, hold_r_d, hold_l_q, hold_l_d;
  logic [c_stale_w-1:0]  stale_q, stale_d;
  logic [c_deb_w-1:0]    deb_cnt_q, deb_cnt_d;
  logic                  deb_q, deb_d;
  logic                  dis_latch_q, dis_latch_d;
  logic                  fault_q, dis_q;

  logic signed [8:0]     w_off;
  logic                  w_right, w_left, w_clr_r, w_clr_l;
  logic                  w_sup_r, w_sup_l;
  logic                  w_fault_d, w_dis_d;

  assign w_off   = {lane_if.offset[7], lane_if.offset};
  assign w_right = (w_off > c_thr_pos);
  assign w_left  = (w_off < c_thr_neg);
  assign w_clr_r = (w_off < c_clr_pos);
  assign w_clr_l = (w_off > c_clr_neg);

  // A side is blocked while its signal is on and for HOLDOFF ticks after it drops.
  assign w_sup_r = lane_if.turn_right | (hold_r_q != '0);
  assign w_sup_l = lane_if.turn_left  | (hold_l_q != '0);

  // Next-state of holdoff timers, stale counter and button debouncer.
  always_comb begin
    hold_r_d    = hold_r_q;
    hold_l_d    = hold_l_q;
    stale_d     = stale_q;
    deb_cnt_d   = deb_cnt_q;
    deb_d       = deb_q;
    dis_latch_d = dis_latch_q;

    if (lane_if.turn_right)                     hold_r_d = c_hold;
    else if (lane_if.tick && hold_r_q != '0)    hold_r_d = hold_r_q - c_hold_one;
    if (lane_if.turn_left)                      hold_l_d = c_hold;
    else if (lane_if.tick && hold_l_q != '0)    hold_l_d = hold_l_q - c_hold_one;

    // A fresh sample wins over a simultaneous tick.
    if (lane_if.offset_valid)                   stale_d = '0;
    else if (lane_if.tick && stale_q != c_timeout) stale_d = stale_q + c_stale_one;

    if (lane_if.tick) begin
      if (lane_if.disable_btn != deb_q) begin
        if (deb_cnt_q == c_deb_last) begin
          deb_d     = lane_if.disable_btn;
          deb_cnt_d = '0;
          if (lane_if.disable_btn) dis_latch_d = ~dis_latch_q;
        end else begin
          deb_cnt_d = deb_cnt_q + c_deb_one;
        end
      end else begin
        deb_cnt_d = '0;
      end
    end
  end

  // Fault and disable are taken from next-state values so they land one register stage after their cause.
  assign w_fault_d = (stale_d >= c_timeout);
  assign w_dis_d   = dis_latch_d | (lane_if.speed < c_min_speed) | w_fault_d;

  // Timer, debounce and disable registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_r_q    <= '0;
      hold_l_q    <= '0;
      stale_q     <= '0;
      deb_cnt_q   <= '0;
      deb_q       <= 1'b0;
      dis_latch_q <= 1'b0;
      fault_q     <= 1'b0;
      dis_q       <= 1'b0;
    end else begin
      hold_r_q    <= hold_r_d;
      hold_l_q    <= hold_l_d;
      stale_q     <= stale_d;
      deb_cnt_q   <= deb_cnt_d;
      deb_q       <= deb_d;
      dis_latch_q <= dis_latch_d;
      fault_q     <= w_fault_d;
      dis_q       <= w_dis_d;
    end
  end

  // Departure FSM with registered assist outputs; disable and suppression override sampling.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pers_q     <= '0;
      assist_r_q <= 1'b0;
      assist_l_q <= 1'b0;
    end else if (w_dis_d) begin
      state_q    <= S_IDLE;
      pers_q     <= '0;
      assist_r_q <= 1'b0;
      assist_l_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lane_if.offset_valid && w_right && !w_sup_r) begin
            if (PERSIST == 1) begin
              state_q    <= S_DEP_R;
              assist_r_q <= 1'b1;
            end else begin
              state_q <= S_PEND_R;
              pers_q  <= c_pers_one;
            end
          end else if (lane_if.offset_valid && w_left && !w_sup_l) begin
            if (PERSIST == 1) begin
              state_q    <= S_DEP_L;
              assist_l_q <= 1'b1;
            end else begin
              state_q <= S_PEND_L;
              pers_q  <= c_pers_one;
            end
          end
        end
        S_PEND_R: begin
          if (w_sup_r) begin
            state_q <= S_IDLE;
            pers_q  <= '0;
          end else if (lane_if.offset_valid) begin
            if (w_right && pers_q == c_pers_last) begin
              state_q    <= S_DEP_R;
              pers_q     <= '0;
              assist_r_q <= 1'b1;
            end else if (w_right) begin
              pers_q <= pers_q + c_pers_one;
            end else begin
              state_q <= S_IDLE;
              pers_q  <= '0;
            end
          end
        end
        S_PEND_L: begin
          if (w_sup_l) begin
            state_q <= S_IDLE;
            pers_q  <= '0;
          end else if (lane_if.offset_valid) begin
            if (w_left && pers_q == c_pers_last) begin
              state_q    <= S_DEP_L;
              pers_q     <= '0;
              assist_l_q <= 1'b1;
            end else if (w_left) begin
              pers_q <= pers_q + c_pers_one;
            end else begin
              state_q <= S_IDLE;
              pers_q  <= '0;
            end
          end
        end
        S_DEP_R: begin
          if (w_sup_r || (lane_if.offset_valid && w_clr_r)) begin
            state_q    <= S_IDLE;
            assist_r_q <= 1'b0;
          end
        end
        S_DEP_L: begin
          if (w_sup_l || (lane_if.offset_valid && w_clr_l)) begin
            state_q    <= S_IDLE;
            assist_l_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          pers_q     <= '0;
          assist_r_q <= 1'b0;
          assist_l_q <= 1'b0;
        end
      endcase
    end
  end

  assign lane_if.assist_right   = assist_r_q;
  assign lane_if.assist_left    = assist_l_q;
  assign lane_if.assist_disable = dis_q;
  assign lane_if.sensor_fault   = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_lane_departure_detect.sv
`default_nettype none
// ============================================================================
// Module  : tb_lane_departure_detect
// Purpose : Self-checking bench for lane_departure_detect: directed scenarios
//           followed by randomized traffic, all compared against a
//           behavioural reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lane_departure_detect;
  localparam int THRESH    = 20;
  localparam int HYST      = 5;
  localparam int PERSIST   = 4;
  localparam int HOLDOFF   = 50;
  localparam int DEBOUNCE  = 3;
  localparam int TIMEOUT   = 8;
  localparam int MIN_SPEED = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Level inputs held between steps
  bit   g_tl = 0, g_tr = 0, g_btn = 0;
  int   g_spd = 60;

  // Reference model state
  int   m_hr, m_hl, m_stale, m_dbc;
  bit   m_deb, m_latch, m_fault, m_dis;
  int   m_streak;   // >0: consecutive right samples, <0: consecutive left samples
  int   m_active;   // +1 right departure, -1 left departure, 0 none

  lane_departure_detect_if lane_if ();

  lane_departure_detect #(
    .THRESH(THRESH), .HYST(HYST), .PERSIST(PERSIST), .HOLDOFF(HOLDOFF),
    .DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT), .MIN_SPEED(MIN_SPEED)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .lane_if(lane_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0b expected %0b", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hr = 0; m_hl = 0; m_stale = 0; m_dbc = 0;
    m_deb = 0; m_latch = 0; m_fault = 0; m_dis = 0;
    m_streak = 0; m_active = 0;
  endtask

  // One clock edge of the intended behaviour, written in terms of the rules.
  task automatic model_step(input bit tk, input bit v, input int off);
    bit sup_r, sup_l, is_r, is_l;
    sup_r = g_tr || (m_hr != 0);
    sup_l = g_tl || (m_hl != 0);
    is_r  = off > THRESH;
    is_l  = off < -THRESH;

    if (g_tr) m_hr = HOLDOFF; else if (tk && m_hr > 0) m_hr--;
    if (g_tl) m_hl = HOLDOFF; else if (tk && m_hl > 0) m_hl--;

    if (v) m_stale = 0; else if (tk && m_stale < TIMEOUT) m_stale++;
    m_fault = (m_stale >= TIMEOUT);

    if (tk) begin
      if (g_btn != m_deb) begin
        m_dbc++;
        if (m_dbc == DEBOUNCE) begin
          m_deb = g_btn;
          m_dbc = 0;
          if (g_btn) m_latch = !m_latch;
        end
      end else begin
        m_dbc = 0;
      end
    end
    m_dis = m_latch || (g_spd < MIN_SPEED) || m_fault;

    if (m_dis) begin
      m_active = 0;
      m_streak = 0;
    end else if (m_active == 1) begin
      if (sup_r || (v && off < THRESH - HYST)) m_active = 0;
    end else if (m_active == -1) begin
      if (sup_l || (v && off > -(THRESH - HYST))) m_active = 0;
    end else if ((m_streak > 0 && sup_r) || (m_streak < 0 && sup_l)) begin
      m_streak = 0;
    end else if (v) begin
      if (m_streak > 0)      m_streak = is_r ? m_streak + 1 : 0;
      else if (m_streak < 0) m_streak = is_l ? m_streak - 1 : 0;
      else if (is_r && !sup_r) m_streak = 1;
      else if (is_l && !sup_l) m_streak = -1;
      if (m_streak >= PERSIST) begin
        m_active = 1;  m_streak = 0;
      end else if (m_streak <= -PERSIST) begin
        m_active = -1; m_streak = 0;
      end
    end
  endtask

  task automatic step(input bit tk, input bit v, input int off);
    lane_if.tick         = tk;
    lane_if.offset_valid = v;
    lane_if.offset       = 8'(off);
    lane_if.turn_left    = g_tl;
    lane_if.turn_right   = g_tr;
    lane_if.disable_btn  = g_btn;
    lane_if.speed        = 8'(g_spd);
    model_step(tk, v, off);
    @(posedge clk);
    #1;
    check_val("ar", lane_if.assist_right,   m_active == 1);
    check_val("al", lane_if.assist_left,    m_active == -1);
    check_val("ad", lane_if.assist_disable, m_dis);
    check_val("sf", lane_if.sensor_fault,   m_fault);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lane_if.tick = 1'b0;
    lane_if.offset_valid = 1'b0;
    #1;
    check_val("rst_ar", lane_if.assist_right,   1'b0);
    check_val("rst_al", lane_if.assist_left,    1'b0);
    check_val("rst_ad", lane_if.assist_disable, 1'b0);
    check_val("rst_sf", lane_if.sensor_fault,   1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int vpct;
    int off;
    lane_if.tick = 0; lane_if.offset_valid = 0; lane_if.offset = '0;
    lane_if.turn_left = 0; lane_if.turn_right = 0; lane_if.disable_btn = 0;
    lane_if.speed = 8'd60;
    #3;
    do_reset();

    // Right departure: rise on 4th sample, hysteresis hold, clear
    g_spd = 60;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 25);
      check_val("A_rise", lane_if.assist_right, i == 3);
    end
    step(0, 1, 16); check_val("A_hold",  lane_if.assist_right, 1'b1);
    step(0, 1, 14); check_val("A_clear", lane_if.assist_right, 1'b0);

    // Broken left streak restarts persistence
    repeat (3) step(0, 1, -30);
    step(0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, -30);
      check_val("B_left", lane_if.assist_left, i == 3);
    end

    // Turn-signal holdoff
    g_tr = 1;
    repeat (10) step(1, 1, 40);
    g_tr = 0;
    for (int i = 1; i <= 54; i++) begin
      step(1, 1, 40);
      check_val("C_hold", lane_if.assist_right, i == 54);
    end

    // Stale sensor
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 0);
      check_val("D_fault", lane_if.sensor_fault, i == 8);
    end
    check_val("D_dis",  lane_if.assist_disable, 1'b1);
    check_val("D_drop", lane_if.assist_right,   1'b0);
    step(0, 1, 0);
    check_val("D_fclr", lane_if.sensor_fault,   1'b0);
    check_val("D_dclr", lane_if.assist_disable, 1'b0);

    // Button debounce and toggle
    g_btn = 1; repeat (2) step(1, 1, 0);
    g_btn = 0; repeat (3) step(1, 1, 0);
    check_val("E_short", lane_if.assist_disable, 1'b0);
    g_btn = 1;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0);
      check_val("E_on", lane_if.assist_disable, i == 2);
    end
    g_btn = 0; repeat (3) step(1, 1, 0);
    check_val("E_stay", lane_if.assist_disable, 1'b1);
    g_btn = 1;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0);
      check_val("E_off", lane_if.assist_disable, i != 2);
    end
    g_btn = 0; repeat (3) step(1, 1, 0);

    // Low speed disables assist
    g_spd = 39;
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 50);
      check_val("F_dis", lane_if.assist_disable, 1'b1);
      check_val("F_noa", lane_if.assist_right,   1'b0);
    end
    g_spd = 40;
    step(1, 1, 50);
    check_val("F_en", lane_if.assist_disable, 1'b0);

    // Reset mid-persistence discards the count
    g_spd = 60;
    step(1, 1, 0);
    repeat (3) step(1, 1, -30);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 1, -30);
      check_val("G_left", lane_if.assist_left, i == 3);
    end

    // Randomized traffic
    vpct = 50;
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 0) begin
        case ($urandom % 3)
          0:       vpct = 10;
          1:       vpct = 50;
          default: vpct = 90;
        endcase
      end
      if (g_tr) begin
        if ($urandom % 8 == 0) g_tr = 0;
      end else if ($urandom % 300 == 0) g_tr = 1;
      if (g_tl) begin
        if ($urandom % 8 == 0) g_tl = 0;
      end else if ($urandom % 300 == 0) g_tl = 1;
      if ($urandom % 6 == 0)   g_btn = ~g_btn;
      if ($urandom % 100 == 0) g_spd = int'($urandom_range(30, 90));
      if ($urandom % 8 == 0)
        off = int'($urandom_range(0, 255)) - 128;
      else if ($urandom % 2 == 0)
        off = int'($urandom_range(8, 30));
      else
        off = -int'($urandom_range(8, 30));
      if ($urandom % 1500 == 0)
        do_reset();
      else
        step(($urandom % 3) == 0, int'($urandom % 100) < vpct, off);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
